washer_ctrl_param: RTL and testbench
====================================

# washer_ctrl_param

Parametrised wash-machine sequencer, next generation of the team's washer FSM. It replaces the external Tf/Tw/Td/Tr/Ts timer inputs with internal per-phase duration counters. It adds a runtime-selectable rinse count (0..2^RINSE_W-1), a door-open pause/resume with hold, and an abort path that forces a drain. It sits between the front-panel inputs and the valve/motor drivers.

## Interface
- T_FILL, 4: fill duration in clk cycles (≥1)
- T_WASH, 6: wash duration (≥1)
- T_DRAIN, 3: drain duration (≥1)
- T_RINSE, 5: rinse-agitate duration (≥1)
- T_SPIN, 8: spin duration (≥1)
- TW, 16: phase timer width; every T_* must be < 2^TW
- RINSE_W, 2: width of rinse-count input
---
- clk  in  1  single clock, all logic on rising edge
- reset  in  1  synchronous, active-low (0 = reset, sampled on clk rising edge)
- start  in  1  begin a cycle (honoured only in IDLE with door=0)
- door  in  1  door open; pauses any running phase
- abort  in  1  cancel running cycle, go to forced drain
- rinses  in  RINSE_W  number of rinse passes, latched at start
- water  out  1  fill valve
- agitator  out  1  agitator drive
- pump  out  1  drain pump
- motor  out  1  drum motor
- speed  out  1  high-speed spin select
- hold  out  1  phase paused by open door
- busy  out  1  state ≠ IDLE
- done  out  1  one-cycle pulse on normal completion
- state  out  3  current state code

## Operation
- States/codes: IDLE 0, FILL1 1, WASH 2, DRAIN1 3, FILL2 4, RINSE 5, DRAIN2 6, SPIN 7.
- Outputs are Moore-decoded from state, forced to 0 while hold=1:
  - FILL1/FILL2: water.
  - WASH/RINSE: agitator.
  - DRAIN1/DRAIN2: pump.
  - SPIN: motor, pump, speed.
  - IDLE: all 0.
- IDLE→FILL1 when start=1 and door=0. On that edge, latch rinses into rinse_left.
- Each phase loads its timer with T_x-1 on entry and decrements each un-held cycle. It exits on the cycle the timer is 0 and hold=0.
- Transition order: FILL1→WASH→DRAIN1.
  - From DRAIN1: go to FILL2 if rinse_left≠0, else to SPIN.
  - Each FILL2 entry decrements rinse_left. Then FILL2→RINSE→DRAIN2.
  - From DRAIN2: go to FILL2 if rinse_left≠0, else to SPIN.
  - SPIN→IDLE, with done=1 for the first IDLE cycle.
- Door: hold is a register.
  - Set on any edge with door=1 and state≠IDLE. Cleared on any edge with door=0.
  - While hold=1 the timer and state are frozen.
  - In IDLE, door blocks start; hold stays 0.
- Abort (state≠IDLE, abort=1): next state is DRAIN2 with rinse_left cleared and an aborting flag set.
  - DRAIN2 with the aborting flag exits to IDLE, not SPIN, and done stays 0.
  - Abort overrides door. hold clears on the abort edge, and the abort drain ignores door.
  - Abort while already in an aborting DRAIN2 is ignored.
- Simultaneous start and abort in IDLE: start wins, abort is ignored.

## Timing
- Reset (reset=0 at an edge) gives:
  - state=IDLE;
  - timer, rinse_left, hold, done and aborting all 0;
  - all outputs 0.
- Reset mid-cycle has the same effect and takes priority over every input.
- Start latency: start sampled at edge E gives state=FILL1 from after E.
- Each phase is visible for exactly T_x cycles plus the number of held cycles.
- Cycles from the start edge to the IDLE edge equal 2·T_FILL+T_WASH+2·T_DRAIN+T_SPIN+(n−1)·(T_FILL+T_RINSE+T_DRAIN)+T_RINSE for n≥1 rinses. For n=0 they equal T_FILL+T_WASH+T_DRAIN+T_SPIN.
- A door pulse spanning D sampled edges inside a running phase adds exactly D cycles.
- done is high for exactly one cycle, the first IDLE cycle after SPIN.
- done is low after abort or reset.

## Test plan
- Default params, rinses=1, start for one cycle → state sequence 1,2,3,4,5,6,7 with lengths 4,6,3,4,5,3,8. IDLE and done=1 come 33 cycles after the start edge, with done low the next cycle.
- rinses=2 → FILL2/RINSE/DRAIN2 visited twice; done 45 cycles after start. rinses=0 → 1,2,3,7; done at 21 cycles.
- door=1 for 5 edges mid-WASH → hold=1 for 5 cycles with agitator=0 during them. WASH lasts 11 cycles and done arrives at 38. start with door=1 in IDLE → stays IDLE.
- abort in RINSE → next state DRAIN2 with pump=1 for 3 cycles, then IDLE with done=0 and SPIN never entered. abort with door=1 in WASH → same forced drain and hold=0.
- reset=0 for one edge during SPIN → all outputs 0 and state=0 the next cycle. A new start then runs a full cycle correctly.
- Non-default params (T_*=1, RINSE_W=3, rinses=7) → each phase lasts one cycle, 7 rinse passes, and the total matches the formula.

Source files
------------

// File: rtl/washer_ctrl_param.sv
// Wash-machine sequencer with internal per-phase timers, selectable rinse passes,
// door pause/resume and an abort path that forces a drain before returning to idle.
module washer_ctrl_param #(
    parameter int T_FILL  = 4,
    parameter int T_WASH  = 6,
    parameter int T_DRAIN = 3,
    parameter int T_RINSE = 5,
    parameter int T_SPIN  = 8,
    parameter int TW      = 16,
    parameter int RINSE_W = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               door,
    input  logic               abort,
    input  logic [RINSE_W-1:0] rinses,
    output logic               water,
    output logic               agitator,
    output logic               pump,
    output logic               motor,
    output logic               speed,
    output logic               hold,
    output logic               busy,
    output logic               done,
    output logic [2:0]         state
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FILL1  = 3'd1,
        WASH   = 3'd2,
        DRAIN1 = 3'd3,
        FILL2  = 3'd4,
        RINSE  = 3'd5,
        DRAIN2 = 3'd6,
        SPIN   = 3'd7
    } state_t;

    state_t             state_q, state_d;
    logic [TW-1:0]      timer_q, timer_d;
    logic [RINSE_W-1:0] rinseLeft_q, rinseLeft_d;
    logic               aborting_q, aborting_d;
    logic               hold_q, hold_d;
    logic               done_q, done_d;
    logic               water_q, agitator_q, pump_q, motor_q, speed_q, busy_q;

    function automatic logic [TW-1:0] phaseLoad(input state_t s);
        case (s)
            FILL1, FILL2:   phaseLoad = TW'(T_FILL - 1);
            WASH:           phaseLoad = TW'(T_WASH - 1);
            DRAIN1, DRAIN2: phaseLoad = TW'(T_DRAIN - 1);
            RINSE:          phaseLoad = TW'(T_RINSE - 1);
            SPIN:           phaseLoad = TW'(T_SPIN - 1);
            default:        phaseLoad = '0;
        endcase
    endfunction

    // A phase only advances when not held; it leaves on the cycle its timer reads zero.
    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        rinseLeft_d = rinseLeft_q;
        aborting_d  = aborting_q;
        done_d      = 1'b0;
        if (state_q == IDLE) begin
            if (start && !door) begin
                state_d     = FILL1;
                timer_d     = phaseLoad(FILL1);
                rinseLeft_d = rinses;
                aborting_d  = 1'b0;
            end
        end else if (abort && !aborting_q) begin
            state_d     = DRAIN2;
            timer_d     = phaseLoad(DRAIN2);
            rinseLeft_d = '0;
            aborting_d  = 1'b1;
        end else if (!hold_q) begin
            if (timer_q != '0) begin
                timer_d = timer_q - TW'(1);
            end else begin
                case (state_q)
                    FILL1:  state_d = WASH;
                    WASH:   state_d = DRAIN1;
                    FILL2:  state_d = RINSE;
                    RINSE:  state_d = DRAIN2;
                    DRAIN1, DRAIN2: begin
                        if (aborting_q) begin
                            state_d    = IDLE;
                            aborting_d = 1'b0;
                        end else if (rinseLeft_q != '0) begin
                            state_d     = FILL2;
                            rinseLeft_d = rinseLeft_q - RINSE_W'(1);
                        end else begin
                            state_d = SPIN;
                        end
                    end
                    SPIN: begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                    default: state_d = IDLE;
                endcase
                timer_d = phaseLoad(state_d);
            end
        end
        hold_d = door && (state_q != IDLE) && (state_d != IDLE) && !aborting_d;
    end

    // Drive outputs are decoded from the next state so they line up with the state register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            timer_q     <= '0;
            rinseLeft_q <= '0;
            aborting_q  <= 1'b0;
            hold_q      <= 1'b0;
            done_q      <= 1'b0;
            water_q     <= 1'b0;
            agitator_q  <= 1'b0;
            pump_q      <= 1'b0;
            motor_q     <= 1'b0;
            speed_q     <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            rinseLeft_q <= rinseLeft_d;
            aborting_q  <= aborting_d;
            hold_q      <= hold_d;
            done_q      <= done_d;
            water_q     <= !hold_d && (state_d == FILL1 || state_d == FILL2);
            agitator_q  <= !hold_d && (state_d == WASH || state_d == RINSE);
            pump_q      <= !hold_d && (state_d == DRAIN1 || state_d == DRAIN2 || state_d == SPIN);
            motor_q     <= !hold_d && (state_d == SPIN);
            speed_q     <= !hold_d && (state_d == SPIN);
            busy_q      <= (state_d != IDLE);
        end
    end

    assign water    = water_q;
    assign agitator = agitator_q;
    assign pump     = pump_q;
    assign motor    = motor_q;
    assign speed    = speed_q;
    assign hold     = hold_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign state    = state_q;

endmodule

// File: tb/tb_washer_ctrl_param.sv
// Self-checking bench for washer_ctrl_param: a phase-list reference model checks every cycle
// under directed and random stimulus; a second instance exercises one-cycle phases.
module tb_washer_ctrl_param;

    localparam int F = 4, W = 6, D = 3, R = 5, S = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, start, door, abort;
    logic [1:0] rinses;
    logic       water, agitator, pump, motor, speed, hold, busy, done;
    logic [2:0] state;

    logic       startB;
    logic [2:0] rinsesB;
    logic       waterB, agitatorB, pumpB, motorB, speedB, holdB, busyB, doneB;
    logic [2:0] stateB;

    int errors = 0;
    int checks = 0;

    int phaseQ[$];
    int remaining;
    bit mHold, mDone, mAborting;

    washer_ctrl_param dut (
        .clk(clk), .reset(reset), .start(start), .door(door), .abort(abort), .rinses(rinses),
        .water(water), .agitator(agitator), .pump(pump), .motor(motor), .speed(speed),
        .hold(hold), .busy(busy), .done(done), .state(state)
    );

    washer_ctrl_param #(
        .T_FILL(1), .T_WASH(1), .T_DRAIN(1), .T_RINSE(1), .T_SPIN(1), .TW(16), .RINSE_W(3)
    ) dutB (
        .clk(clk), .reset(reset), .start(startB), .door(1'b0), .abort(1'b0), .rinses(rinsesB),
        .water(waterB), .agitator(agitatorB), .pump(pumpB), .motor(motorB), .speed(speedB),
        .hold(holdB), .busy(busyB), .done(doneB), .state(stateB)
    );

    function automatic int dur(input int c);
        case (c)
            1, 4:    return F;
            2:       return W;
            3, 6:    return D;
            5:       return R;
            7:       return S;
            default: return 0;
        endcase
    endfunction

    function automatic int totalCycles(input int n, f, w, d, r, s);
        if (n == 0) return f + w + d + s;
        return 2*f + w + 2*d + s + (n-1)*(f + r + d) + r;
    endfunction

    // Reference: the run is a list of phases; the head phase is what the machine shows.
    task automatic modelEdge(input bit s, input bit d, input bit a, input bit rstN, input int r);
        if (!rstN) begin
            phaseQ.delete();
            mHold = 0; mDone = 0; mAborting = 0;
            return;
        end
        mDone = 0;
        if (phaseQ.size() == 0) begin
            if (s && !d) begin
                phaseQ = {1, 2, 3};
                repeat (r) begin
                    phaseQ.push_back(4); phaseQ.push_back(5); phaseQ.push_back(6);
                end
                phaseQ.push_back(7);
                remaining = dur(1);
            end
            mHold = 0;
        end else if (a && !mAborting) begin
            phaseQ = {6};
            remaining = D;
            mAborting = 1;
            mHold = 0;
        end else begin
            if (!mHold) begin
                remaining--;
                if (remaining == 0) begin
                    void'(phaseQ.pop_front());
                    if (phaseQ.size() == 0) begin
                        mDone = !mAborting;
                        mAborting = 0;
                    end else begin
                        remaining = dur(phaseQ[0]);
                    end
                end
            end
            mHold = d && (phaseQ.size() != 0) && !mAborting;
        end
    endtask

    function automatic logic [10:0] expOuts();
        int c;
        bit on;
        c  = (phaseQ.size() == 0) ? 0 : phaseQ[0];
        on = !mHold;
        return {3'(c), on && (c == 1 || c == 4), on && (c == 2 || c == 5),
                on && (c == 3 || c == 6 || c == 7), on && (c == 7), on && (c == 7),
                mHold, c != 0, mDone};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic applyStimulus(input bit s, input bit d, input bit a, input bit rstN, input logic [1:0] r);
        start = s; door = d; abort = a; reset = rstN; rinses = r;
        @(posedge clk);
        #1;
        modelEdge(s, d, a, rstN, int'(r));
        checkOutput("outs", 32'({state, water, agitator, pump, motor, speed, hold, busy, done}),
                    32'(expOuts()));
    endtask

    // Start a run and step it until idle, with optional door window, abort edge and reset edge.
    task automatic runCycle(input logic [1:0] r, input int doorAt, input int doorLen,
                            input int abortAt, input int resetAt,
                            output int cycles, output int holdCycles, output int pumpAfterAbort,
                            output bit sawSpin, output bit doneAtEnd);
        holdCycles = 0; pumpAfterAbort = 0; sawSpin = 0; cycles = 0;
        applyStimulus(1, 0, 0, 1, r);
        for (int i = 1; i < 300; i++) begin
            applyStimulus(0, (i >= doorAt && i < doorAt + doorLen), (i == abortAt), (i != resetAt), r);
            if (hold) holdCycles++;
            if (state == 3'd7) sawSpin = 1;
            if (abortAt > 0 && i >= abortAt && pump) pumpAfterAbort++;
            if (!busy) begin
                cycles = i;
                break;
            end
        end
        doneAtEnd = done;
        checkOutput("idle_reached", 32'(busy), 32'(0));
    endtask

    int  cyc, hc, pa;
    bit  spin, dn;
    bit  dLevel;
    int  seqB[$];

    initial begin
        startB = 0; rinsesB = '0;
        applyStimulus(0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("reset_state", 32'({state, water, agitator, pump, motor, speed, hold, busy, done}), 32'(0));
        applyStimulus(0, 0, 0, 1, 0);

        runCycle(2'd1, 0, 0, 0, 0, cyc, hc, pa, spin, dn);
        checkOutput("len_r1", 32'(cyc), 32'(totalCycles(1, F, W, D, R, S)));
        checkOutput("done_r1", 32'(dn), 32'(1));
        applyStimulus(0, 0, 0, 1, 0);
        checkOutput("done_low_after", 32'(done), 32'(0));

        runCycle(2'd2, 0, 0, 0, 0, cyc, hc, pa, spin, dn);
        checkOutput("len_r2", 32'(cyc), 32'(totalCycles(2, F, W, D, R, S)));
        runCycle(2'd0, 0, 0, 0, 0, cyc, hc, pa, spin, dn);
        checkOutput("len_r0", 32'(cyc), 32'(totalCycles(0, F, W, D, R, S)));

        runCycle(2'd1, 6, 5, 0, 0, cyc, hc, pa, spin, dn);
        checkOutput("hold_cycles", 32'(hc), 32'(5));
        checkOutput("len_door", 32'(cyc), 32'(totalCycles(1, F, W, D, R, S) + 5));

        applyStimulus(1, 1, 0, 1, 1);
        checkOutput("door_blocks_start", 32'(busy), 32'(0));
        applyStimulus(0, 0, 0, 1, 1);

        runCycle(2'd1, 0, 0, 19, 0, cyc, hc, pa, spin, dn);
        checkOutput("abort_pump", 32'(pa), 32'(D));
        checkOutput("abort_nospin", 32'(spin), 32'(0));
        checkOutput("abort_nodone", 32'(dn), 32'(0));
        checkOutput("abort_len", 32'(cyc), 32'(19 + D));

        runCycle(2'd1, 5, 6, 8, 0, cyc, hc, pa, spin, dn);
        checkOutput("abort_door_len", 32'(cyc), 32'(8 + D));
        checkOutput("abort_door_pump", 32'(pa), 32'(D));

        runCycle(2'd0, 0, 0, 0, 15, cyc, hc, pa, spin, dn);
        checkOutput("reset_spin_outs", 32'({state, water, agitator, pump, motor, speed, hold, busy, done}), 32'(0));
        checkOutput("reset_spin_at", 32'(cyc), 32'(15));
        runCycle(2'd2, 0, 0, 0, 0, cyc, hc, pa, spin, dn);
        checkOutput("len_after_reset", 32'(cyc), 32'(totalCycles(2, F, W, D, R, S)));
        checkOutput("done_after_reset", 32'(dn), 32'(1));

        dLevel = 0;
        for (int k = 0; k < 1500; k++) begin
            if ($urandom_range(0, 5) == 0) dLevel = !dLevel;
            applyStimulus($urandom_range(0, 3) == 0, dLevel, $urandom_range(0, 40) == 0,
                          $urandom_range(0, 300) != 0, 2'($urandom_range(0, 3)));
        end
        applyStimulus(0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 1, 0);

        seqB = {1, 2, 3};
        repeat (7) begin
            seqB.push_back(4); seqB.push_back(5); seqB.push_back(6);
        end
        seqB.push_back(7);
        startB = 1; rinsesB = 3'd7;
        applyStimulus(0, 0, 0, 1, 0);
        startB = 0; rinsesB = 3'd0;
        cyc = 0;
        while (seqB.size() != 0) begin
            checkOutput("b_state", 32'(stateB), 32'(seqB.pop_front()));
            applyStimulus(0, 0, 0, 1, 0);
            cyc++;
        end
        checkOutput("b_len", 32'(cyc), 32'(totalCycles(7, 1, 1, 1, 1, 1)));
        checkOutput("b_idle_done", 32'({stateB, doneB}), 32'({3'd0, 1'b1}));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
